bus_rr_arbiter: RTL
===================

// Module: bus_rr_arbiter
// PURPOSE
// - Round-robin arbiter sharing the single system bus between NUM_MASTERS bus masters (ramDmaCi DMA, CPU, camera, ...).
// - Takes each master's requestTransaction and returns a one-cycle transactionGranted pulse.
// - Tracks the granted transaction from begin to end/error, so the bus is never double-granted.
// PARAMETERS
// - NUM_MASTERS     4     number of requesters, 2..8; index 0 = CPU
// - TIMEOUT_CYCLES  1024  watchdog limit in cycles (used only with BUS_WATCHDOG_EN)
// PORTS
// - clock               in   1            system clock; all state changes on rising edge
// - reset               in   1            synchronous, active-high
// - requestTransaction  in   NUM_MASTERS  per-master request, level, held until its transaction ends
// - transactionGranted  out  NUM_MASTERS  one-hot, one-cycle grant pulse
// - beginTransactionIn  in   1            bus begin strobe (OR of all masters' beginTransactionOut)
// - endTransactionIn    in   1            bus end strobe (master or slave end, ORed)
// - busErrorIn          in   1            bus error; terminates the current transaction
// - activeMaster        out  $clog2(NUM_MASTERS)  index of the current or last owner
// - busIdle             out  1            1 when the state is IDLE
// - watchdogTimeout     out  1            one-cycle pulse on watchdog expiry (tied 0 when the watchdog is compiled out)
// BEHAVIOUR
// - Reset values: transactionGranted=0, activeMaster=0, busIdle=1, watchdogTimeout=0, state=IDLE, rrPointer=0.
// - Reset mid-transaction returns to IDLE in the next cycle and drops any grant. Masters are reset by the same reset.
// - Request selection: pick the first set requestTransaction[i], scanning from i=rrPointer upward and wrapping modulo NUM_MASTERS.
// - IDLE:
//   - If any request is set at edge t, register the winner k, drive transactionGranted[k]=1 during cycle t+1 only, and go to WAIT_BEGIN.
//   - Grant latency is 1 cycle.
//   - beginTransactionIn or endTransactionIn seen in IDLE is ignored.
// - WAIT_BEGIN:
//   - beginTransactionIn=1 -> BUSY. Begin and end in the same cycle (single-beat) -> TURNAROUND directly.
//   - requestTransaction[k] drops before begin -> TURNAROUND (abandoned grant, rrPointer still advances).
// - BUSY:
//   - endTransactionIn=1 or busErrorIn=1 -> TURNAROUND. Error and end in the same cycle count as one termination.
//   - Requests from other masters are latched by level only and wait.
// - TURNAROUND:
//   - Lasts exactly 1 cycle (bus handover gap), then IDLE.
//   - Sets rrPointer=(k+1) mod NUM_MASTERS. Wrap: k=NUM_MASTERS-1 -> 0.
//   - Requests asserted during TURNAROUND are arbitrated in the following IDLE cycle.
// - Minimum spacing between two grants is 3 cycles (grant, begin+end, turnaround) plus the IDLE decision cycle.
// - Exactly one grant is outstanding at any time. transactionGranted never has more than one bit set.
// - activeMaster updates together with the grant and holds until the next grant.
// CONFIGURATION
// - BUS_WATCHDOG_EN defined:
//   - A cycle counter clears on grant and counts in WAIT_BEGIN and BUSY.
//   - On reaching TIMEOUT_CYCLES: watchdogTimeout pulses 1 cycle, state -> TURNAROUND, rrPointer advances.
// - BUS_WATCHDOG_EN undefined:
//   - No counter is instantiated; watchdogTimeout=0 constant.
//   - A master that never ends its transaction stalls the bus indefinitely.
// STRUCTURE
// - Package bus_arb_pkg:
//   - state enum {IDLE, WAIT_BEGIN, BUSY, TURNAROUND}
//   - localparam MAX_MASTERS=8
//   - default TIMEOUT_CYCLES
//   - idx width helper function
// - Sub-module rr_priority_pick: combinational rotate / priority-encode / unrotate; inputs req vector and pointer; outputs index and valid.
// - Top level holds the FSM, the pointer, the registered grant and the optional watchdog counter.
// TESTING
// - Single requester: req[2]=1 at cycle 5 -> grant[2] pulses cycle 6 only; begin cycle 9, end cycle 20 -> busIdle=1 at cycle 22, rrPointer=3.
// - Contention: req=4'b1111 held, each master ends 4 cycles after begin -> grant order 0,1,2,3,0; never two grant bits set.
// - Wrap: rrPointer=3, req=4'b1001 -> grant[3] first, then grant[0].
// - Single-beat plus error: begin and end in the same cycle -> TURNAROUND next cycle; busErrorIn in BUSY -> same release, pointer advances.
// - Reset mid-BUSY: assert reset for 1 cycle during a DMA burst -> next cycle state IDLE, grants 0, rrPointer 0.
// - Watchdog (BUS_WATCHDOG_EN, TIMEOUT_CYCLES=16): grant with no begin -> watchdogTimeout pulses 16 cycles after grant, next master served; rebuilt without the macro -> arbiter stays in WAIT_BEGIN.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin system-bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BEGIN = 2'd1,
        BUSY       = 2'd2,
        TURNAROUND = 2'd3
    } bus_state_e;

    localparam int unsigned MAX_MASTERS        = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    // Width of a master index; at least 1 bit, capped at the supported master count.
    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned m;
        m = (n > MAX_MASTERS) ? MAX_MASTERS : n;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Arbiter-facing view of the shared system bus: requests, strobes and grant/status.
interface bus_rr_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
);

    logic [NUM_MASTERS-1:0]       requestTransaction;
    logic [NUM_MASTERS-1:0]       transactionGranted;
    logic                         beginTransactionIn;
    logic                         endTransactionIn;
    logic                         busErrorIn;
    logic [idx_w(NUM_MASTERS)-1:0] activeMaster;
    logic                         busIdle;
    logic                         watchdogTimeout;

    modport slave (
        input  requestTransaction,
        input  beginTransactionIn,
        input  endTransactionIn,
        input  busErrorIn,
        output transactionGranted,
        output activeMaster,
        output busIdle,
        output watchdogTimeout
    );

    modport master (
        output requestTransaction,
        output beginTransactionIn,
        output endTransactionIn,
        output busErrorIn,
        input  transactionGranted,
        input  activeMaster,
        input  busIdle,
        input  watchdogTimeout
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so the pointer sits at bit 0, take the
// lowest set bit, then map the offset back to an absolute master index.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]        req_i,
    input  logic [idx_w(N)-1:0] ptr_i,
    output logic [idx_w(N)-1:0] idx_c_o,
    output logic                valid_c_o
);

    localparam int unsigned IW = idx_w(N);
    localparam int unsigned SW = IW + 1;

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [SW-1:0] sum;

    always_comb begin
        rot       = N'({req_i, req_i} >> ptr_i);
        off       = '0;
        valid_c_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !valid_c_o) begin
                valid_c_o = 1'b1;
                off       = IW'(i);
            end
        end
        // Unrotate; pointer and offset are both below N so one subtraction wraps.
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        idx_c_o = sum[IW-1:0];
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner of the single system bus: one grant pulse per transaction,
// tracked begin..end/error, then a one-cycle handover gap. Optional watchdog
// is compiled in with BUS_WATCHDOG_EN.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clock,
    input  logic            reset,
    bus_rr_arbiter_if.slave bus
);

    localparam int unsigned NM = NUM_MASTERS;
    localparam int unsigned IW = idx_w(NUM_MASTERS);

    localparam logic [1:0] ST_IDLE       = 2'(IDLE);
    localparam logic [1:0] ST_WAIT_BEGIN = 2'(WAIT_BEGIN);
    localparam logic [1:0] ST_BUSY       = 2'(BUSY);
    localparam logic [1:0] ST_TURNAROUND = 2'(TURNAROUND);

    logic [1:0]    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          idle_q, idle_d;

    logic [NM-1:0] req_w;
    logic [IW-1:0] pick_idx_c;
    logic          pick_valid_c;
    logic          wdt_expire_c;

    assign req_w = bus.requestTransaction;

    rr_priority_pick #(
        .N (NM)
    ) u_pick (
        .req_i     (req_w),
        .ptr_i     (ptr_q),
        .idx_c_o   (pick_idx_c),
        .valid_c_o (pick_valid_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ST_WAIT_BEGIN;
                    grant_d = NM'(1) << pick_idx_c;
                    owner_d = pick_idx_c;
                end
            end
            ST_WAIT_BEGIN: begin
                if (wdt_expire_c) begin
                    state_d = ST_TURNAROUND;
                end else if (bus.beginTransactionIn) begin
                    state_d = bus.endTransactionIn ? ST_TURNAROUND : ST_BUSY;
                end else if (!req_w[owner_q]) begin
                    state_d = ST_TURNAROUND;
                end
            end
            ST_BUSY: begin
                if (wdt_expire_c || bus.endTransactionIn || bus.busErrorIn) begin
                    state_d = ST_TURNAROUND;
                end
            end
            ST_TURNAROUND: begin
                state_d = ST_IDLE;
                ptr_d   = (owner_q == IW'(NM - 1)) ? '0 : owner_q + IW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.transactionGranted = grant_q;
    assign bus.activeMaster       = owner_q;
    assign bus.busIdle            = idle_q;

`ifdef BUS_WATCHDOG_EN
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_q;
    logic             in_txn_c;

    // Counter is zero on the grant cycle and expires after TIMEOUT_CYCLES owned cycles.
    assign in_txn_c     = (state_q == ST_WAIT_BEGIN) || (state_q == ST_BUSY);
    assign wdt_expire_c = in_txn_c && (wdt_cnt_q == WDT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if (state_q == ST_IDLE) begin
            wdt_cnt_d = '0;
        end else if (in_txn_c) begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wdt_cnt_q <= '0;
            wdt_q     <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_q     <= wdt_expire_c;
        end
    end

    assign bus.watchdogTimeout = wdt_q;
`else
    // Without the watchdog the timeout parameter has no consumer.
    logic [31:0] unused_timeout;
    assign unused_timeout      = 32'(TIMEOUT_CYCLES);
    assign wdt_expire_c        = 1'b0;
    assign bus.watchdogTimeout = 1'b0;
`endif

endmodule
